// File: rtl/player_mover.sv
// Two-player tile mover: validates one move request at a time and commits it on a frame tick.
// Optional build macro PLAYER_MOVER_WRAP_EN makes off-grid targets wrap to the opposite edge.
module player_mover #(
  parameter int HMAXTILE        = 9,
  parameter int VMAXTILE        = 5,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    key_valid,
  output logic                                    key_ready,
  input  logic                                    key_player,
  input  logic [1:0]                              key_dir,
  input  logic                                    frame_tick,
  input  logic [(HMAXTILE+1)*(VMAXTILE+1):0]      walkAble,
  output logic [3:0]                              curAh,
  output logic [3:0]                              curAv,
  output logic [3:0]                              curBh,
  output logic [3:0]                              curBv,
  output logic                                    move_ok,
  output logic                                    move_rej,
  output logic [1:0]                              rej_code
);

  localparam int WALK_W = (HMAXTILE + 1) * (VMAXTILE + 1) + 1;
  localparam int IW     = $clog2(WALK_W);
  localparam logic signed [5:0] HMAX_S = 6'(HMAXTILE);
  localparam logic signed [5:0] VMAX_S = 6'(VMAXTILE);

  typedef enum logic [1:0] {IDLE, EVAL, WAIT} state_t;

  state_t state, nextState;

  logic              reqPlayer_p0;
  logic [1:0]        reqDir_p0;
  logic [3:0]        tgtH_p1, tgtV_p1;
  logic [3:0]        cdA, cdB;

  logic [3:0]        selH, selV, othH, othV, selCd;
  logic signed [5:0] rawH, rawV;
  logic [3:0]        th, tv;
  logic              offGrid, bound, occupied, walkOk, fail;
  logic [IW-1:0]     idx;
  logic [1:0]        rejCode;
  logic              doAccept, doReject, doPass, doCommit;

  function automatic logic [3:0] nextCd(input logic [3:0] cd, input logic tick,
                                        input logic load);
    if (load) return 4'(COOLDOWN_FRAMES);
    if (tick && cd != 4'd0) return cd - 4'd1;
    return cd;
  endfunction

  // Evaluation stage: target tile and rejection checks for the latched request
  always_comb begin
    selH  = reqPlayer_p0 ? curBh : curAh;
    selV  = reqPlayer_p0 ? curBv : curAv;
    othH  = reqPlayer_p0 ? curAh : curBh;
    othV  = reqPlayer_p0 ? curAv : curBv;
    selCd = reqPlayer_p0 ? cdB : cdA;
    rawH  = signed'({2'b00, selH});
    rawV  = signed'({2'b00, selV});
    case (reqDir_p0)
      2'd0:    rawV = rawV - 6'sd1;
      2'd1:    rawV = rawV + 6'sd1;
      2'd2:    rawH = rawH - 6'sd1;
      default: rawH = rawH + 6'sd1;
    endcase
    offGrid = (rawH < 6'sd0) || (rawH > HMAX_S) || (rawV < 6'sd0) || (rawV > VMAX_S);
`ifdef PLAYER_MOVER_WRAP_EN
    th    = (rawH < 6'sd0) ? 4'(HMAXTILE) : (rawH > HMAX_S) ? 4'd0 : rawH[3:0];
    tv    = (rawV < 6'sd0) ? 4'(VMAXTILE) : (rawV > VMAX_S) ? 4'd0 : rawV[3:0];
    bound = 1'b0;
`else
    th    = rawH[3:0];
    tv    = rawV[3:0];
    bound = offGrid;
`endif
    // An off-grid index would point outside the map, so park it on tile 0
    idx      = bound ? '0 : (IW'(tv) * IW'(HMAXTILE + 1) + IW'(th));
    walkOk   = walkAble[idx];
    occupied = (th == othH) && (tv == othV);
    fail     = 1'b1;
    rejCode  = 2'd0;
    if (selCd != 4'd0)  rejCode = 2'd3;
    else if (bound)     rejCode = 2'd0;
    else if (!walkOk)   rejCode = 2'd1;
    else if (occupied)  rejCode = 2'd2;
    else                fail = 1'b0;
  end

  always_comb begin
    nextState = state;
    key_ready = 1'b0;
    doAccept  = 1'b0;
    doReject  = 1'b0;
    doPass    = 1'b0;
    doCommit  = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          doAccept  = 1'b1;
          nextState = EVAL;
        end
      end
      EVAL: begin
        doReject  = fail;
        doPass    = !fail;
        nextState = fail ? IDLE : WAIT;
      end
      WAIT: begin
        if (frame_tick) begin
          doCommit  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Commit stage: positions, cooldowns and result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      curAh    <= 4'd0;
      curAv    <= 4'd0;
      curBh    <= 4'(HMAXTILE);
      curBv    <= 4'(VMAXTILE);
      cdA      <= 4'd0;
      cdB      <= 4'd0;
      move_ok  <= 1'b0;
      move_rej <= 1'b0;
      rej_code <= 2'd0;
    end else begin
      move_ok  <= doCommit;
      move_rej <= doReject;
      if (doReject) rej_code <= rejCode;
      cdA <= nextCd(cdA, frame_tick, doCommit && !reqPlayer_p0);
      cdB <= nextCd(cdB, frame_tick, doCommit && reqPlayer_p0);
      if (doCommit && !reqPlayer_p0) begin
        curAh <= tgtH_p1;
        curAv <= tgtV_p1;
      end
      if (doCommit && reqPlayer_p0) begin
        curBh <= tgtH_p1;
        curBv <= tgtV_p1;
      end
    end
  end

  // Request and target latches carry no reset; the FSM qualifies them
  always_ff @(posedge clk) begin
    if (doAccept) begin
      reqPlayer_p0 <= key_player;
      reqDir_p0    <= key_dir;
    end
    if (doPass) begin
      tgtH_p1 <= th;
      tgtV_p1 <= tv;
    end
  end

endmodule
